// File: rtl/mod_exp_ladder_pkg.sv
// mod_exp_ladder_pkg: shared state encodings and default operand sizing for mod_exp_ladder
package mod_exp_ladder_pkg;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int NUM_WORDS_DEF = 32;
  localparam int KEY_WIDTH = DATA_WIDTH_DEF * NUM_WORDS_DEF;
  typedef enum logic [4:0] {
    S_IDLE = 5'd0, S_LOAD = 5'd1, S_LOADED = 5'd2, S_INIT = 5'd3,
    S_BIT = 5'd4, S_MUL = 5'd5, S_TERMINAL = 5'd6, S_OUTPUT = 5'd7
  } main_state_e;
  typedef enum logic [2:0] {
    M_IDLE = 3'd0, M_DBL = 3'd1, M_ADD = 3'd2, M_DONE = 3'd3
  } sub_state_e;
endpackage

// File: rtl/mod_exp_ladder_mod_mult.sv
// mod_mult: bit-serial interleaved modular multiplier, MSB-first over b, done one cycle after DONE
module mod_mult import mod_exp_ladder_pkg::*; #(
  parameter int W = 8,
  parameter logic [W-1:0] M = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  output logic         done,
  output logic [2:0]   sub_state
);
  localparam int JW = W > 1 ? $clog2(W) : 1;
  localparam logic [W:0] M1 = {1'b0, M};
  sub_state_e state_q, state_d;
  logic [W-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [JW-1:0] j_q, j_d;
  logic done_q, done_d;
  logic [W:0] dbl, sum, dbl_r, sum_r;
  always_comb begin
    dbl = {acc_q, 1'b0};
    sum = {1'b0, acc_q} + (b_q[j_q] ? {1'b0, a_q} : '0);
    dbl_r = dbl >= M1 ? dbl - M1 : dbl;
    sum_r = sum >= M1 ? sum - M1 : sum;
    state_d = state_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    j_d = j_q;
    done_d = state_q == M_DONE;
    case (state_q)
      M_IDLE: if (start) begin
        state_d = M_DBL;
        acc_d = '0;
        a_d = a;
        b_d = b;
        j_d = JW'(W - 1);
      end
      M_DBL: begin
        acc_d = dbl_r[W-1:0];
        state_d = M_ADD;
      end
      M_ADD: begin
        acc_d = sum_r[W-1:0];
        j_d = j_q - JW'(1);
        state_d = j_q == '0 ? M_DONE : M_DBL;
      end
      default: state_d = M_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= M_IDLE;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      j_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      j_q <= j_d;
      done_q <= done_d;
    end
  end
  assign p = acc_q;
  assign done = done_q;
  assign sub_state = state_q;
endmodule

// File: rtl/mod_exp_ladder.sv
// mod_exp_ladder: Montgomery-ladder modexp over word-streamed base; LADDER_SKIP_LEADING_ZEROS_EN starts at the exponent MSB one
module mod_exp_ladder import mod_exp_ladder_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter logic [DATA_WIDTH*NUM_WORDS-1:0] MODULUS = '1,
  parameter logic [DATA_WIDTH*NUM_WORDS-1:0] EXPONENT = 'h10001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startInput,
  input  logic                  startCompute,
  input  logic                  getResult,
  input  logic [DATA_WIDTH-1:0] inp,
  output logic [4:0]            stateModExp,
  output logic [2:0]            stateModExpSub,
  output logic [DATA_WIDTH-1:0] outp
);
  localparam int KW = DATA_WIDTH * NUM_WORDS;
  localparam int IW = KW > 1 ? $clog2(KW) : 1;
  localparam int CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0] ONE_MOD = MODULUS == KW'(1) ? '0 : KW'(1);
`ifdef LADDER_SKIP_LEADING_ZEROS_EN
  function automatic int msb_of(input logic [KW-1:0] v);
    int r = 0;
    for (int n = 0; n < KW; n++) if (v[n]) r = n;
    return r;
  endfunction
  localparam logic [IW-1:0] I_START = IW'(msb_of(EXPONENT));
  localparam bit EXP_ZERO = EXPONENT == '0;
`else
  localparam logic [IW-1:0] I_START = IW'(KW - 1);
  localparam bit EXP_ZERO = 1'b0;
`endif
  main_state_e state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [KW-1:0] base_q, base_d, r0_q, r0_d, r1_q, r1_d, pa, pb, sq;
  logic [IW-1:0] i_q, i_d;
  logic pend_q, pend_d;
  logic [DATA_WIDTH-1:0] outp_q, outp_d, word;
  logic start, e_bit, done_a, done_b, mul_done;
  logic [2:0] sub_b;
  assign e_bit = EXPONENT[i_q];
  assign sq = e_bit ? r1_q : r0_q;
  assign mul_done = done_a & done_b & (sub_b == M_IDLE);
  assign word = r0_q[k_q*DATA_WIDTH +: DATA_WIDTH];
  mod_mult #(.W(KW), .M(MODULUS)) u_mul_a (
    .clk(clk), .rst(reset), .start(start), .a(r0_q), .b(r1_q),
    .p(pa), .done(done_a), .sub_state(stateModExpSub)
  );
  mod_mult #(.W(KW), .M(MODULUS)) u_mul_b (
    .clk(clk), .rst(reset), .start(start), .a(sq), .b(sq),
    .p(pb), .done(done_b), .sub_state(sub_b)
  );
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    base_d = base_q;
    r0_d = r0_q;
    r1_d = r1_q;
    i_d = i_q;
    outp_d = outp_q;
    start = 1'b0;
    pend_d = pend_q | (getResult && state_q inside {S_LOADED, S_INIT, S_BIT, S_MUL});
    case (state_q)
      S_IDLE: if (startInput) begin
        state_d = S_LOAD;
        k_d = '0;
      end
      S_LOAD: begin
        base_d[k_q*DATA_WIDTH +: DATA_WIDTH] = inp;
        k_d = k_q == CW'(NUM_WORDS - 1) ? '0 : k_q + CW'(1);
        state_d = k_q == CW'(NUM_WORDS - 1) ? S_LOADED : S_LOAD;
      end
      S_LOADED: if (startCompute) state_d = S_INIT;
      S_INIT: begin
        r1_d = base_q >= MODULUS ? base_q - MODULUS : base_q;
        r0_d = ONE_MOD;
        i_d = I_START;
        state_d = EXP_ZERO ? S_TERMINAL : S_BIT;
      end
      S_BIT: begin
        start = 1'b1;
        state_d = S_MUL;
      end
      S_MUL: if (mul_done) begin
        r0_d = e_bit ? pa : pb;
        r1_d = e_bit ? pb : pa;
        i_d = i_q - IW'(1);
        state_d = i_q == '0 ? S_TERMINAL : S_BIT;
      end
      S_TERMINAL: if (getResult || pend_q) begin
        state_d = S_OUTPUT;
        k_d = '0;
        pend_d = 1'b0;
      end
      S_OUTPUT: begin
        outp_d = word;
        k_d = k_q == CW'(NUM_WORDS - 1) ? '0 : k_q + CW'(1);
        state_d = k_q == CW'(NUM_WORDS - 1) ? S_IDLE : S_OUTPUT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q <= '0;
      base_q <= '0;
      r0_q <= '0;
      r1_q <= '0;
      i_q <= '0;
      pend_q <= 1'b0;
      outp_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      base_q <= base_d;
      r0_q <= r0_d;
      r1_q <= r1_d;
      i_q <= i_d;
      pend_q <= pend_d;
      outp_q <= outp_d;
    end
  end
  assign stateModExp = state_q;
  assign outp = state_q == S_OUTPUT ? word : outp_q;
endmodule

// File: tb/tb_mod_exp_ladder.sv
// tb_mod_exp_ladder: directed and random modexp transactions on three ladder configurations against a square-and-multiply model
module tb_mod_exp_ladder;
  localparam int KS = 8;
  localparam int KB = 16;
  localparam logic [7:0] MS = 8'hBB;
  localparam logic [15:0] MB = 16'hC35B;
  localparam logic [15:0] EB = 16'hB3A5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_in = 1'b0;
  logic s_cmp = 1'b0;
  logic get = 1'b0;
  logic [3:0] in_s = '0;
  logic [7:0] in_b = '0;
  logic [4:0] st [3];
  logic [2:0] sub [3];
  logic [3:0] o7, o0;
  logic [7:0] ob;
  logic [7:0] op [3];
  logic [15:0] last_s7;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign op[0] = {4'h0, o7};
  assign op[1] = {4'h0, o0};
  assign op[2] = ob;
  mod_exp_ladder #(.DATA_WIDTH(4), .NUM_WORDS(2), .MODULUS(MS), .EXPONENT(8'd7)) u_e7 (
    .clk(clk), .reset(reset), .startInput(s_in), .startCompute(s_cmp), .getResult(get),
    .inp(in_s), .stateModExp(st[0]), .stateModExpSub(sub[0]), .outp(o7)
  );
  mod_exp_ladder #(.DATA_WIDTH(4), .NUM_WORDS(2), .MODULUS(MS), .EXPONENT(8'd0)) u_e0 (
    .clk(clk), .reset(reset), .startInput(s_in), .startCompute(s_cmp), .getResult(get),
    .inp(in_s), .stateModExp(st[1]), .stateModExpSub(sub[1]), .outp(o0)
  );
  mod_exp_ladder #(.DATA_WIDTH(8), .NUM_WORDS(2), .MODULUS(MB), .EXPONENT(EB)) u_big (
    .clk(clk), .reset(reset), .startInput(s_in), .startCompute(s_cmp), .getResult(get),
    .inp(in_b), .stateModExp(st[2]), .stateModExpSub(sub[2]), .outp(ob)
  );
  function automatic longint unsigned pow_mod(longint unsigned b, longint unsigned e, longint unsigned m);
    longint unsigned r = 1 % m;
    b = b % m;
    while (e != 0) begin
      if ((e & 1) != 0) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic run(input logic [7:0] bs, input logic [15:0] bb, input bit hold, input int abort_at);
    int term [3];
    int nout [3];
    logic [7:0] got [3][2];
    bit fin [3];
    logic [15:0] res [3];
    logic [15:0] expv [3];
    int lat [3];
    int cyc;
    for (int i = 0; i < 3; i++) begin
      term[i] = -1;
      nout[i] = 0;
      fin[i] = 1'b0;
      got[i][0] = '0;
      got[i][1] = '0;
    end
    s_in = 1'b1;
    tick;
    s_in = 1'b0;
    for (int w = 0; w < 2; w++) begin
      in_s = bs[w*4 +: 4];
      in_b = bb[w*8 +: 8];
      tick;
    end
    for (int i = 0; i < 3; i++) check($sformatf("loaded%0d", i), 32'(st[i]), 32'd2);
    get = hold;
    s_cmp = 1'b1;
    tick;
    s_cmp = 1'b0;
    cyc = 0;
    while (!(fin[0] && fin[1] && fin[2]) && cyc < 3000) begin
      tick;
      cyc++;
      if (cyc == abort_at) begin
        check("pre_abort_mul", 32'(st[0]), 32'd5);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        get = 1'b0;
        for (int i = 0; i < 3; i++) check($sformatf("abort_state%0d", i), 32'(st[i]), 32'd0);
        check("abort_sub", 32'(sub[0]), 32'd0);
        check("abort_outp", 32'(op[0]), 32'd0);
        return;
      end
      for (int i = 0; i < 3; i++) begin
        if (st[i] == 5'd6 && term[i] < 0) term[i] = cyc;
        if (st[i] == 5'd7) begin
          if (nout[i] < 2) got[i][nout[i]] = op[i];
          nout[i]++;
        end
        if (st[i] == 5'd0 && nout[i] > 0) fin[i] = 1'b1;
      end
      if (st[0] == 5'd6 && st[1] == 5'd6 && st[2] == 5'd6) get = 1'b1;
    end
    get = 1'b0;
    check("timeout", 32'(fin[0] && fin[1] && fin[2]), 32'd1);
    expv[0] = 16'(pow_mod(64'(bs), 64'd7, 64'(MS)));
    expv[1] = 16'(pow_mod(64'(bs), 64'd0, 64'(MS)));
    expv[2] = 16'(pow_mod(64'(bb), 64'(EB), 64'(MB)));
    lat[0] = 1 + KS * (2 * KS + 3);
    lat[1] = lat[0];
    lat[2] = 1 + KB * (2 * KB + 3);
    res[0] = {8'h0, got[0][1][3:0], got[0][0][3:0]};
    res[1] = {8'h0, got[1][1][3:0], got[1][0][3:0]};
    res[2] = {got[2][1], got[2][0]};
    last_s7 = res[0];
    for (int i = 0; i < 3; i++) begin
      check($sformatf("latency%0d", i), 32'(term[i]), 32'(lat[i]));
      check($sformatf("nwords%0d", i), 32'(nout[i]), 32'd2);
      check($sformatf("result%0d", i), 32'(res[i]), 32'(expv[i]));
      check($sformatf("hold%0d", i), 32'(op[i]), 32'(got[i][1]));
    end
  endtask
  initial begin
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_state%0d", i), 32'(st[i]), 32'd0);
      check($sformatf("rst_sub%0d", i), 32'(sub[i]), 32'd0);
      check($sformatf("rst_outp%0d", i), 32'(op[i]), 32'd0);
    end
    reset = 1'b0;
    tick;
    s_cmp = 1'b1;
    tick;
    tick;
    s_cmp = 1'b0;
    for (int i = 0; i < 3; i++) check($sformatf("idle_ignore%0d", i), 32'(st[i]), 32'd0);
    run(8'd88, 16'($urandom_range(0, 65535)), 1'b0, 0);
    check("base88", 32'(last_s7), 32'd11);
    run(8'hC0, 16'($urandom_range(0, 65535)), 1'b0, 0);
    check("baseC0", 32'(last_s7), 32'd146);
    run(8'd88, 16'($urandom_range(0, 65535)), 1'b0, 50);
    run(8'd88, 16'($urandom_range(0, 65535)), 1'b0, 0);
    check("reload88", 32'(last_s7), 32'd11);
    run(8'd0, 16'($urandom_range(0, 65535)), 1'b1, 0);
    run(MS, MB, 1'b0, 0);
    run(8'hFF, 16'd0, 1'b1, 0);
    repeat (3) run(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
